// File: rtl/emin_sweep_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : emin_sweep_scheduler
// Purpose  : Launches one Emin sweep per end index i and solves the segmentation
//            DP C(i) = min_j C(j) + Emin(j,i) + SEG_PENALTY, emitting backpointers.
// Revision : 1.0 - initial release
// ============================================================================
module emin_sweep_scheduler #(
  parameter  int          BIT_WIDTH   = 32,
  parameter  int          I           = 160,
  parameter  int          COST_WIDTH  = 40,
  parameter  int unsigned SEG_PENALTY = 0,
  parameter  int          TIMEOUT     = 1024,
  localparam int          IW          = $clog2(I)
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        start_in,
  input  logic [IW-1:0]               num_i_in,
  output logic [IW-1:0]               emin_i_out,
  output logic                        emin_valid_out,
  input  logic [IW-1:0]               emin_j_in,
  input  logic signed [BIT_WIDTH-1:0] emin_data_in,
  input  logic                        emin_valid_in,
  output logic                        bp_we_out,
  output logic [IW-1:0]               bp_addr_out,
  output logic [IW-1:0]               bp_data_out,
  output logic [COST_WIDTH-1:0]       best_cost_out,
  output logic                        busy_out,
  output logic                        done_out,
  output logic                        error_out
);

  localparam int c_wd_w  = $clog2(TIMEOUT + 1);
  localparam int c_sum_w = ((COST_WIDTH > BIT_WIDTH) ? COST_WIDTH : BIT_WIDTH) + 2;
  localparam logic [IW-1:0]     c_max_n  = IW'(I - 1);
  localparam logic [c_wd_w-1:0] c_wd_end = c_wd_w'(TIMEOUT - 1);

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_launch  = 3'd1;
  localparam logic [2:0] c_st_collect = 3'd2;
  localparam logic [2:0] c_st_commit  = 3'd3;
  localparam logic [2:0] c_st_finish  = 3'd4;

  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;
  logic [IW-1:0]         r_i;
  logic [IW-1:0]         r_n;
  logic [COST_WIDTH-1:0] r_best;
  logic [IW-1:0]         r_arg;
  logic [c_wd_w-1:0]     r_wd;
  logic [COST_WIDTH-1:0] r_cost [0:I-1];
  logic [COST_WIDTH-1:0] r_best_cost;
  logic                  r_busy;
  logic                  r_error;
  logic                  r_done;
  logic                  r_launch;
  logic                  r_bp_we;
  logic [IW-1:0]         r_emin_i;
  logic [IW-1:0]         r_bp_addr;
  logic [IW-1:0]         r_bp_data;

  logic                  w_accept;
  logic                  w_hit;
  logic                  w_cand_ok;
  logic                  w_sweep_end;
  logic                  w_timeout;
  logic                  w_last;
  logic                  w_better;
  logic [IW-1:0]         w_n_clamped;
  logic [c_sum_w-1:0]    w_cj;
  logic [c_sum_w-1:0]    w_d;
  logic [c_sum_w-1:0]    w_sum;
  logic [COST_WIDTH-1:0] w_cand;
  logic                  w_launch_nxt;
  logic                  w_commit_nxt;
  logic                  w_done_nxt;

  assign w_accept    = (r_state == c_st_idle) && start_in;
  assign w_n_clamped = (num_i_in > c_max_n) ? c_max_n : num_i_in;
  assign w_hit       = (r_state == c_st_collect) && emin_valid_in;
  assign w_cand_ok   = w_hit && (emin_j_in < r_i);
  assign w_sweep_end = w_hit && (emin_j_in == r_i);
  assign w_timeout   = (r_state == c_st_collect) && !emin_valid_in && (r_wd == c_wd_end);
  assign w_last      = (r_i == r_n);

  // Candidate cost: negative Emin counts as zero, sum saturates at the cost width.
  assign w_cj     = c_sum_w'(r_cost[emin_j_in]);
  assign w_d      = emin_data_in[BIT_WIDTH-1] ? '0 : c_sum_w'($unsigned(emin_data_in));
  assign w_sum    = w_cj + w_d + c_sum_w'(SEG_PENALTY);
  assign w_cand   = (|w_sum[c_sum_w-1:COST_WIDTH]) ? '1 : w_sum[COST_WIDTH-1:0];
  assign w_better = w_cand_ok && (w_cand < r_best);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (start_in) begin
          w_state_nxt = (w_n_clamped == '0) ? c_st_finish : c_st_launch;
        end
      end
      c_st_launch:  w_state_nxt = c_st_collect;
      c_st_collect: begin
        if (w_timeout) begin
          w_state_nxt = c_st_idle;
        end else if (w_sweep_end) begin
          w_state_nxt = c_st_commit;
        end
      end
      c_st_commit:  w_state_nxt = w_last ? c_st_finish : c_st_launch;
      c_st_finish:  w_state_nxt = c_st_idle;
      default:      w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    w_launch_nxt = 1'b0;
    w_commit_nxt = 1'b0;
    w_done_nxt   = 1'b0;
    case (r_state)
      c_st_launch: w_launch_nxt = 1'b1;
      c_st_commit: w_commit_nxt = 1'b1;
      c_st_finish: w_done_nxt   = 1'b1;
      default:     ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_i         <= '0;
      r_n         <= '0;
      r_best      <= '0;
      r_arg       <= '0;
      r_wd        <= '0;
      r_best_cost <= '0;
      r_busy      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_n         <= w_n_clamped;
        r_i         <= IW'(1);
        r_error     <= 1'b0;
        r_busy      <= 1'b1;
        r_best_cost <= '0;
      end
      case (r_state)
        c_st_launch: begin
          r_best <= '1;
          r_arg  <= '0;
          r_wd   <= '0;
        end
        c_st_collect: begin
          if (emin_valid_in) begin
            r_wd <= '0;
          end else begin
            r_wd <= r_wd + c_wd_w'(1);
          end
          if (w_better) begin
            r_best <= w_cand;
            r_arg  <= emin_j_in;
          end
          if (w_timeout) begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        c_st_commit: begin
          if (w_last) begin
            r_best_cost <= r_best;
          end else begin
            r_i <= r_i + IW'(1);
          end
        end
        c_st_finish: r_busy <= 1'b0;
        default:     ;
      endcase
    end
  end

  // Cost table has no reset; C(0) is seeded on every accepted start.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      if (w_accept) begin
        r_cost[0] <= '0;
      end else if (w_commit_nxt) begin
        r_cost[r_i] <= r_best;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_launch  <= 1'b0;
      r_bp_we   <= 1'b0;
      r_done    <= 1'b0;
      r_emin_i  <= '0;
      r_bp_addr <= '0;
      r_bp_data <= '0;
    end else begin
      r_launch <= w_launch_nxt;
      r_bp_we  <= w_commit_nxt;
      r_done   <= w_done_nxt;
      if (w_launch_nxt) begin
        r_emin_i <= r_i;
      end
      if (w_commit_nxt) begin
        r_bp_addr <= r_i;
        r_bp_data <= r_arg;
      end
    end
  end

  assign emin_i_out     = r_emin_i;
  assign emin_valid_out = r_launch;
  assign bp_we_out      = r_bp_we;
  assign bp_addr_out    = r_bp_addr;
  assign bp_data_out    = r_bp_data;
  assign best_cost_out  = r_best_cost;
  assign busy_out       = r_busy;
  assign done_out       = r_done;
  assign error_out      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_emin_sweep_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_emin_sweep_scheduler
// Purpose  : Directed bench with a small Emin responder; two DUTs share stimulus
//            (SEG_PENALTY 0 and 10, TIMEOUT 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_emin_sweep_scheduler;

  logic               clk = 1'b0;
  logic               rst;
  logic               start_in;
  logic [7:0]         num_i_in;
  logic [7:0]         emin_i_out, p_emin_i_out;
  logic               emin_valid_out, p_emin_valid_out;
  logic [7:0]         emin_j_in;
  logic signed [31:0] emin_data_in;
  logic               emin_valid_in;
  logic               bp_we_out, p_bp_we_out;
  logic [7:0]         bp_addr_out, p_bp_addr_out;
  logic [7:0]         bp_data_out, p_bp_data_out;
  logic [39:0]        best_cost_out, p_best_cost_out;
  logic               busy_out, p_busy_out;
  logic               done_out, p_done_out;
  logic               error_out, p_error_out;

  int checks   = 0;
  int failures = 0;

  logic signed [31:0] etab [0:2][0:2];
  bit                 stall = 1'b0;
  int                 m_i;

  logic [7:0] bp_a[$], bp_d[$], pbp_a[$], pbp_d[$];
  int         done_cnt   = 0;
  int         launch_cnt = 0;

  always #5 clk = ~clk;

  emin_sweep_scheduler #(.SEG_PENALTY(0), .TIMEOUT(16)) dut (
    .clk_in(clk), .rst_in(rst), .start_in(start_in), .num_i_in(num_i_in),
    .emin_i_out(emin_i_out), .emin_valid_out(emin_valid_out),
    .emin_j_in(emin_j_in), .emin_data_in(emin_data_in), .emin_valid_in(emin_valid_in),
    .bp_we_out(bp_we_out), .bp_addr_out(bp_addr_out), .bp_data_out(bp_data_out),
    .best_cost_out(best_cost_out), .busy_out(busy_out), .done_out(done_out),
    .error_out(error_out)
  );

  emin_sweep_scheduler #(.SEG_PENALTY(10), .TIMEOUT(16)) dut_p (
    .clk_in(clk), .rst_in(rst), .start_in(start_in), .num_i_in(num_i_in),
    .emin_i_out(p_emin_i_out), .emin_valid_out(p_emin_valid_out),
    .emin_j_in(emin_j_in), .emin_data_in(emin_data_in), .emin_valid_in(emin_valid_in),
    .bp_we_out(p_bp_we_out), .bp_addr_out(p_bp_addr_out), .bp_data_out(p_bp_data_out),
    .best_cost_out(p_best_cost_out), .busy_out(p_busy_out), .done_out(p_done_out),
    .error_out(p_error_out)
  );

  // Emin responder: two idle cycles after a launch, then j=0..i back to back.
  always begin
    @(negedge clk);
    if (emin_valid_out && !stall) begin
      m_i = int'(emin_i_out);
      repeat (2) @(negedge clk);
      for (int j = 0; j <= m_i; j++) begin
        emin_valid_in = 1'b1;
        emin_j_in     = 8'(j);
        emin_data_in  = etab[j][m_i];
        @(negedge clk);
      end
      emin_valid_in = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (bp_we_out) begin
      bp_a.push_back(bp_addr_out);
      bp_d.push_back(bp_data_out);
    end
    if (p_bp_we_out) begin
      pbp_a.push_back(p_bp_addr_out);
      pbp_d.push_back(p_bp_data_out);
    end
    if (done_out) done_cnt++;
    if (emin_valid_out) launch_cnt++;
  end

  task automatic clear_obs();
    bp_a.delete(); bp_d.delete(); pbp_a.delete(); pbp_d.delete();
    done_cnt   = 0;
    launch_cnt = 0;
  endtask

  task automatic start_frame(input logic [7:0] n);
    @(negedge clk);
    start_in = 1'b1;
    num_i_in = n;
    @(negedge clk);
    start_in = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      if (done_out) ok = 1'b1;
      else @(negedge clk);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (emin_valid_out !== 1'b0) begin failures++; $display("FAIL reset_emin_valid: got %0b want 0", emin_valid_out); end
    checks++; if (bp_we_out !== 1'b0) begin failures++; $display("FAIL reset_bp_we: got %0b want 0", bp_we_out); end
    checks++; if (done_out !== 1'b0 || busy_out !== 1'b0 || error_out !== 1'b0) begin
      failures++; $display("FAIL reset_flags: done=%0b busy=%0b error=%0b want 0", done_out, busy_out, error_out);
    end
    checks++; if (best_cost_out !== 40'd0 || emin_i_out !== 8'd0 || bp_addr_out !== 8'd0 || bp_data_out !== 8'd0) begin
      failures++; $display("FAIL reset_data: best=%0d emin_i=%0d bp_addr=%0d bp_data=%0d want 0", best_cost_out, emin_i_out, bp_addr_out, bp_data_out);
    end
  endtask

  task automatic test_basic();
    bit ok;
    etab[0][1] = 5;  etab[1][1] = 99;
    etab[0][2] = 20; etab[1][2] = 3; etab[2][2] = 0;
    clear_obs();
    start_frame(8'd2);
    checks++; if (busy_out !== 1'b1) begin failures++; $display("FAIL basic_busy: got %0b want 1", busy_out); end
    wait_done(ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_done_wait: no done within bound"); end
    checks++; if (bp_a.size() != 2) begin failures++; $display("FAIL basic_bp_count: got %0d want 2", bp_a.size()); end
    else begin
      checks++; if (bp_a[0] !== 8'd1 || bp_d[0] !== 8'd0) begin failures++; $display("FAIL basic_bp1: got (%0d,%0d) want (1,0)", bp_a[0], bp_d[0]); end
      checks++; if (bp_a[1] !== 8'd2 || bp_d[1] !== 8'd1) begin failures++; $display("FAIL basic_bp2: got (%0d,%0d) want (2,1)", bp_a[1], bp_d[1]); end
    end
    checks++; if (best_cost_out !== 40'd8) begin failures++; $display("FAIL basic_cost: got %0d want 8", best_cost_out); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt); end
    checks++; if (launch_cnt != 2) begin failures++; $display("FAIL basic_launches: got %0d want 2", launch_cnt); end
    checks++; if (busy_out !== 1'b0 || error_out !== 1'b0) begin failures++; $display("FAIL basic_end_flags: busy=%0b error=%0b want 0", busy_out, error_out); end
    checks++; if (p_best_cost_out !== 40'd28) begin failures++; $display("FAIL penalty_cost: got %0d want 28", p_best_cost_out); end
    checks++; if (pbp_d.size() != 2 || pbp_d[1] !== 8'd1) begin failures++; $display("FAIL penalty_bp2: count=%0d want bp(2)=1", pbp_d.size()); end
  endtask

  task automatic test_tie();
    bit ok;
    etab[0][1] = 5; etab[1][1] = 0;
    etab[0][2] = 8; etab[1][2] = 3; etab[2][2] = 0;
    clear_obs();
    start_frame(8'd2);
    wait_done(ok);
    checks++; if (!ok) begin failures++; $display("FAIL tie_done_wait: no done within bound"); end
    checks++; if (bp_d.size() != 2 || bp_d[1] !== 8'd0) begin failures++; $display("FAIL tie_bp2: count=%0d want bp(2)=0", bp_d.size()); end
    checks++; if (best_cost_out !== 40'd8) begin failures++; $display("FAIL tie_cost: got %0d want 8", best_cost_out); end
    checks++; if (p_best_cost_out !== 40'd18 || pbp_d.size() != 2 || pbp_d[1] !== 8'd0) begin
      failures++; $display("FAIL tie_penalty: cost=%0d want 18, bp(2) want 0", p_best_cost_out);
    end
  endtask

  task automatic test_negative();
    bit ok;
    etab[0][1] = -7; etab[1][1] = 50;
    clear_obs();
    start_frame(8'd1);
    wait_done(ok);
    checks++; if (!ok) begin failures++; $display("FAIL neg_done_wait: no done within bound"); end
    checks++; if (bp_a.size() != 1 || bp_a[0] !== 8'd1 || bp_d[0] !== 8'd0) begin failures++; $display("FAIL neg_bp1: count=%0d want (1,0)", bp_a.size()); end
    checks++; if (best_cost_out !== 40'd0) begin failures++; $display("FAIL neg_cost: got %0d want 0", best_cost_out); end
    checks++; if (p_best_cost_out !== 40'd10) begin failures++; $display("FAIL neg_penalty_cost: got %0d want 10", p_best_cost_out); end
  endtask

  task automatic test_n_zero();
    clear_obs();
    start_frame(8'd0);
    checks++; if (done_out !== 1'b0 || busy_out !== 1'b1) begin failures++; $display("FAIL nzero_cycle1: done=%0b busy=%0b want 0/1", done_out, busy_out); end
    @(negedge clk);
    checks++; if (done_out !== 1'b1 || busy_out !== 1'b0) begin failures++; $display("FAIL nzero_cycle2: done=%0b busy=%0b want 1/0", done_out, busy_out); end
    checks++; if (best_cost_out !== 40'd0) begin failures++; $display("FAIL nzero_cost: got %0d want 0", best_cost_out); end
    repeat (6) @(negedge clk);
    checks++; if (launch_cnt != 0 || bp_a.size() != 0 || done_cnt != 1) begin
      failures++; $display("FAIL nzero_activity: launches=%0d bp=%0d done=%0d want 0/0/1", launch_cnt, bp_a.size(), done_cnt);
    end
  endtask

  task automatic test_timeout();
    bit seen, got, ok;
    int cnt;
    stall = 1'b1;
    clear_obs();
    start_frame(8'd2);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (emin_valid_out) seen = 1'b1;
      else @(negedge clk);
    end
    checks++; if (!seen) begin failures++; $display("FAIL timeout_launch: no launch within bound"); end
    got = 1'b0;
    cnt = 0;
    for (int k = 1; k <= 40 && !got; k++) begin
      if (k == 3) begin start_in = 1'b1; num_i_in = 8'd0; end
      else start_in = 1'b0;
      @(negedge clk);
      if (error_out) begin got = 1'b1; cnt = k; end
    end
    start_in = 1'b0;
    checks++; if (cnt != 16) begin failures++; $display("FAIL timeout_cycle: got %0d want 16", cnt); end
    checks++; if (busy_out !== 1'b0) begin failures++; $display("FAIL timeout_busy: got %0b want 0", busy_out); end
    repeat (5) @(negedge clk);
    checks++; if (done_cnt != 0 || bp_a.size() != 0 || launch_cnt != 1) begin
      failures++; $display("FAIL timeout_activity: done=%0d bp=%0d launches=%0d want 0/0/1", done_cnt, bp_a.size(), launch_cnt);
    end
    checks++; if (error_out !== 1'b1) begin failures++; $display("FAIL timeout_sticky: got %0b want 1", error_out); end
    stall = 1'b0;
    etab[0][1] = 4; etab[1][1] = 1;
    clear_obs();
    start_frame(8'd1);
    checks++; if (error_out !== 1'b0 || busy_out !== 1'b1) begin failures++; $display("FAIL restart_flags: error=%0b busy=%0b want 0/1", error_out, busy_out); end
    wait_done(ok);
    checks++; if (!ok || best_cost_out !== 40'd4 || p_best_cost_out !== 40'd14) begin
      failures++; $display("FAIL restart_cost: ok=%0b cost=%0d pcost=%0d want 1/4/14", ok, best_cost_out, p_best_cost_out);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    etab[0][1] = 5; etab[1][1] = 99;
    etab[0][2] = 20; etab[1][2] = 3; etab[2][2] = 0;
    clear_obs();
    start_frame(8'd2);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (emin_valid_out) seen = 1'b1;
      else @(negedge clk);
    end
    checks++; if (!seen) begin failures++; $display("FAIL midrst_launch: no launch within bound"); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    checks++; if (bp_a.size() != 0 || done_cnt != 0 || launch_cnt != 1) begin
      failures++; $display("FAIL midrst_activity: bp=%0d done=%0d launches=%0d want 0/0/1", bp_a.size(), done_cnt, launch_cnt);
    end
    checks++; if (busy_out !== 1'b0 || error_out !== 1'b0) begin failures++; $display("FAIL midrst_flags: busy=%0b error=%0b want 0", busy_out, error_out); end
  endtask

  initial begin
    rst           = 1'b1;
    start_in      = 1'b0;
    num_i_in      = '0;
    emin_j_in     = '0;
    emin_data_in  = '0;
    emin_valid_in = 1'b0;
    for (int a = 0; a < 3; a++) begin
      for (int b = 0; b < 3; b++) etab[a][b] = 0;
    end
    test_reset();
    test_basic();
    test_tie();
    test_negative();
    test_n_zero();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/emin_sweep_scheduler.md
Name: emin_sweep_scheduler

Overview:
- Sequences the pipelined Emin datapath across a whole frame of I samples to solve the segmentation dynamic program.
- For each end index i = 1..N it launches one Emin sweep and consumes the streamed Emin(j,i) results.
- It forms C(i) = min over j<i of (C(j) + Emin(j,i) + SEG_PENALTY) and records the argmin j as a backpointer.
- Sits between the frame controller (start/done) and the Emin block; the backpointer memory is downstream.

Parameters:
- BIT_WIDTH, 32, width of the signed Emin data word.
- I, 160, max samples per frame; index width IW = $clog2(I).
- COST_WIDTH, 40, unsigned accumulated-cost width.
- SEG_PENALTY, 0, unsigned per-segment cost added to every candidate.
- TIMEOUT, 1024, max cycles allowed with no Emin output before an error is declared.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  reset.
- start_in  in  1  pulse; begin a frame solve.
- num_i_in  in  IW  last end index N; sampled on an accepted start.
- emin_i_out  out  IW  end index i presented to Emin.
- emin_valid_out  out  1  one-cycle launch pulse to Emin input_valid.
- emin_j_in  in  IW  Emin j_out.
- emin_data_in  in  BIT_WIDTH  Emin data_out, signed.
- emin_valid_in  in  1  Emin output_valid.
- bp_we_out  out  1  backpointer write strobe.
- bp_addr_out  out  IW  backpointer address, equal to i.
- bp_data_out  out  IW  argmin j for i.
- best_cost_out  out  COST_WIDTH  C(N); valid from done onward.
- busy_out  out  1  high from an accepted start until done or error.
- done_out  out  1  one-cycle pulse at normal completion.
- error_out  out  1  sticky timeout flag; cleared by the next accepted start.

Behaviour:
- Clock and reset: single clock, clk_in. rst_in is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, cost array contents don't-care.
- FSM states:
  - IDLE: start_in accepted only here; start_in in any other state is ignored. On accept: latch N (clamped to I-1), set C(0)=0, clear error_out, busy_out=1, i=1.
    - If N==0: go to FINISH; best_cost_out=0, no launches.
    - Otherwise: go to LAUNCH.
  - LAUNCH (1 cycle): emin_i_out=i, emin_valid_out=1, best=all-ones (COST_WIDTH), arg=0, watchdog=0. Go to COLLECT.
  - COLLECT: on each emin_valid_in with emin_j_in<i:
    - d = emin_data_in clamped to 0 if negative, zero-extended.
    - cand = C(j) + d + SEG_PENALTY, saturating at 2^COST_WIDTH-1.
    - If cand < best (strict; the earlier/smaller j wins ties), update best and arg.
    - Results with j==i are ignored for the minimum; such a result ends the sweep.
    - On j==i: go to COMMIT.
  - COMMIT (1 cycle):
    - Write C(i)=best internally.
    - bp_we_out=1, bp_addr_out=i, bp_data_out=arg.
    - If i==N: best_cost_out=best, go to FINISH. Otherwise i=i+1, go to LAUNCH.
  - FINISH: done_out=1 for one cycle, busy_out=0, go to IDLE.
- Launch spacing: emin_valid_out never asserts while Emin is mid-sweep. The next launch comes at the earliest 2 cycles after the j==i result, which guarantees Emin has returned to its idle state.
- Cost array read: C(j) for the arriving emin_j_in is read in the same cycle it arrives (register array, combinational read). Back-to-back emin_valid_in every cycle must be accepted with no stalls.
- Watchdog: counts cycles in COLLECT since the last emin_valid_in. Reaching TIMEOUT sets error_out=1 and busy_out=0 and returns to IDLE. No done_out is issued and no further bp writes occur.
- Stray input: emin_valid_in outside COLLECT is ignored.
- Reset mid-operation: returns to IDLE immediately. No further bp writes or launches, and error_out is cleared.
- Outputs registered: bp_we_out, done_out and emin_valid_out are single-cycle pulses.

Test Plan:
- N=2, bench Emin model returns:
  - i=1: E(0,1)=5, E(1,1)=99.
  - i=2: E(0,2)=20, E(1,2)=3, E(2,2)=0.
  - Required: bp writes (1,0) then (2,1); best_cost_out=8; one done_out pulse.
- SEG_PENALTY=10 with the same data -> C1=15; C2=min(30, 15+13=28)=28; bp(2)=1.
- Tie: i=2 with E(0,2)=8 and E(1,2)=3, C1=5 -> both candidates are 8; bp_data_out=0.
- Negative Emin: E(0,1)=-7 -> d clamped to 0; C1=0, bp(1)=0.
- N=0 start -> done_out pulse 2 cycles after start; best_cost_out=0; no emin_valid_out, no bp_we_out.
- Model stalls after launch of i=1 with TIMEOUT=16 -> error_out=1 at cycle 16 of silence; busy_out=0; no done_out. A second start while busy is ignored; a new start clears error_out.
